sd_write_photo: RTL and testbench
=================================

# sd_write_photo

- Saves one frame from SDRAM to the SD card as a 24-bit BMP image: header, then pixel data, then zero padding.
- Counterpart of the photo reader:
  - Pulls RGB888 pixels from the SDRAM read port.
  - Packs each pixel pair into three 16-bit SD words and prepends the 54-byte BMP header.
  - Drives the SD sector writer one sector at a time from `PHOTO_SECTION_ADDR0`.
- Sits between the SDRAM read FIFO and the SD write controller (`wr_start_en`/`wr_busy`/`sd_wr_req` interface).

## Interface
Parameters:
- `PHOTO_SECTION_ADDR0`, 32'd41136: first destination sector.
- `H_PIXEL`, 640: image width in pixels. Must be a multiple of 4, so rows need no padding.
- `V_PIXEL`, 480: image height in pixels. Written as positive height (bottom-up).

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `save_trig`  in  1  one-cycle pulse that starts a save.
- `ddr_max_addr`  in  24  pixel count; bit 0 is ignored, so the count is treated as even.
- `sd_sec_num`  in  16  number of sectors to write; must be ≥ 1.
- `wr_busy`  in  1  SD write controller busy.
- `sd_wr_req`  in  1  SD controller consumes the current `sd_wr_data` word. Pulses are at least 4 cycles apart.
- `sdr_rd_data`  in  24  SDRAM pixel `{R,G,B}`, valid the cycle after `sdr_rd_en`.
- `wr_start_en`  out  1  one-cycle pulse that starts a sector write.
- `wr_sec_addr`  out  32  sector address.
- `sd_wr_data`  out  16  word presented to the SD writer (registered).
- `sdr_rd_en`  out  1  SDRAM pixel pop, one cycle per pixel.
- `save_busy`  out  1  high from trigger acceptance until done.
- `save_done`  out  1  one-cycle pulse after the last sector completes.

## Operation
Reset values: every output is 0, all counters are 0, and the sector FSM is in `IDLE`.

Sector FSM: `IDLE` → `START` → `WAIT` → `DONE` → `IDLE`.
- `IDLE`:
  - `save_trig` sets `save_busy`, clears `sec_cnt` and `word_cnt`, and loads `sd_wr_data` with header word 0.
  - Next state `START`.
- `START`: pulse `wr_start_en` with `wr_sec_addr` = `PHOTO_SECTION_ADDR0`; next state `WAIT`.
- `WAIT`: detect the falling edge of `wr_busy` through two-flop delay registers; on the edge, `wr_sec_addr`+1.
  - If `sec_cnt == sd_sec_num-1`: next state `DONE`.
  - Else: `sec_cnt`+1 and pulse `wr_start_en`.
- `DONE`: pulse `save_done`, drop `save_busy`, return to `IDLE`.
- `save_trig` outside `IDLE` is ignored.

Word stream (`word_cnt`, 24 bits, increments on each `sd_wr_req`):
- Words 0–26 are the header. Byte 2k goes in [15:8] and byte 2k+1 in [7:0]. Multi-byte fields are little-endian.
  - Header byte fields: `"BM"`, file size = 54 + 3·N, reserved 0, data offset 54, info size 40, width `H_PIXEL`, height `V_PIXEL`.
  - Further fields: planes 1, bpp 24, compression 0, image size 3·N, resolution 0, colour counts 0.
  - Word 0 = 16'h424D. N = pixel count.
- Pixel words: one group of three words per pixel pair p0, p1. Pixels are `{R[23:16],G[15:8],B[7:0]}`.
  - w0 = {p0.B, p0.G}
  - w1 = {p0.R, p1.B}
  - w2 = {p1.G, p1.R}
- After 27 + 3N/2 words, every remaining word up to `sd_sec_num`·256 is 16'h0000.
- Words requested beyond the end of the stream also return 0.

Pixel fetch:
- Two `sdr_rd_en` pulses on consecutive cycles load the pair registers.
- A fetch is issued on the `sd_wr_req` that consumes the last header word, and on each `sd_wr_req` consuming a w2 with pairs remaining.
- No fetch is issued for the padding region.

## Timing
- `sd_wr_data` updates on the cycle after `sd_wr_req`, with one exception: w0 of a new pair updates two cycles later, once both fetched pixels have landed. Either way the word is valid before the next `sd_wr_req`, which is ≥4 cycles away.
- `sdr_rd_en` pulses occur at req+1 and req+2.
- `wr_start_en` for the first sector: two cycles after `save_trig`.
- `wr_start_en` for later sectors: one cycle after the detected `wr_busy` falling edge. That edge is detected two cycles after the falling edge of `wr_busy`.
- `save_done` is asserted two cycles after the edge detected on the last sector (one cycle into `DONE`).
- An asynchronous reset mid-save aborts immediately with no `save_done`. Counters and outputs return to their reset values.

## Configuration
- `BMP_HEADER_EN`:
  - Defined: the stream is as specified above.
  - Undefined: no header is emitted. Pixel words start at word 0 and `sd_wr_data` loads w0 after the first fetch; trigger acceptance itself issues that fetch. Zero-padding starts at word 3N/2.

## Test plan
- `ddr_max_addr`=4, `sd_sec_num`=1, `save_trig` → exactly one `wr_start_en` with `wr_sec_addr`=41136.
  - Header is 27 words; word 0 = 16'h424D, word 1 = 16'h4200 (file size 66 = 0x42 in the low byte).
  - Words 27–32 = 6 pixel words, then 223 words of 16'h0000.
  - `save_done` is asserted once.
- Pixels 24'hAABBCC and 24'h112233 → words 16'hCCBB, 16'hAA33, 16'h2211.
- `sd_sec_num`=3 → three `wr_start_en` pulses with addresses 41136, 41137, 41138. `save_done` fires only after the third `wr_busy` fall.
- `save_trig` pulsed while `save_busy` is high → no restart and no extra `wr_start_en`.
- `rst_n` low in the middle of sector 2 → all outputs 0 and no `save_done`. A new `save_trig` restarts from word 0 at sector 41136.
- Built without `BMP_HEADER_EN`, same pixels → word 0 = 16'hCCBB and the total non-pad word count is 3.

Source files
------------

// File: rtl/sd_write_photo.sv
// Streams one SDRAM frame to the SD sector writer as a 24-bit BMP (header, BGR pixel pairs, zero pad).
// Optional macro BMP_HEADER_EN enables the 54-byte BMP header; default build emits raw pixel words only.
module sd_write_photo #(
  parameter logic [31:0] PHOTO_SECTION_ADDR0 = 32'd41136,
  parameter int          H_PIXEL             = 640,
  parameter int          V_PIXEL             = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        save_trig,
  input  logic [23:0] ddr_max_addr,
  input  logic [15:0] sd_sec_num,
  input  logic        wr_busy,
  input  logic        sd_wr_req,
  input  logic [23:0] sdr_rd_data,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] sd_wr_data,
  output logic        sdr_rd_en,
  output logic        save_busy,
  output logic        save_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  typedef enum logic [1:0] {REG_HDR, REG_PIX, REG_PAD} region_t;

  state_t      state_r, state_nxt_s;
  region_t     region_r;
  logic [15:0] sec_cnt_r;
  logic        busy_d1_r, busy_d2_r, busy_fall_r;
  logic [23:0] word_cnt_r;
  logic [22:0] pairs_left_r;
  logic [1:0]  phase_r, fetch_step_r;
  logic [23:0] p0_r, p1_r;
  logic        last_sec_s, trig_ok_s, beyond_end_s;
  logic        unused_s;

  assign last_sec_s   = (sec_cnt_r == (sd_sec_num - 16'd1));
  assign trig_ok_s    = (state_r == IDLE) && save_trig;
  assign beyond_end_s = (word_cnt_r >= {sd_sec_num, 8'h00});
  assign unused_s     = ddr_max_addr[0];

`ifdef BMP_HEADER_EN
  logic [23:0] n_pix_r;

  function automatic logic [7:0] header_byte(input logic [5:0] idx, input logic [23:0] n_pix);
    logic [31:0] img_size;
    logic [31:0] file_size;
    logic [31:0] width;
    logic [31:0] height;
    img_size  = {8'h00, n_pix} * 32'd3;
    file_size = img_size + 32'd54;
    width     = 32'(H_PIXEL);
    height    = 32'(V_PIXEL);
    case (idx)
      6'd0:    header_byte = 8'h42;
      6'd1:    header_byte = 8'h4D;
      6'd2:    header_byte = file_size[7:0];
      6'd3:    header_byte = file_size[15:8];
      6'd4:    header_byte = file_size[23:16];
      6'd5:    header_byte = file_size[31:24];
      6'd10:   header_byte = 8'h36;
      6'd14:   header_byte = 8'h28;
      6'd18:   header_byte = width[7:0];
      6'd19:   header_byte = width[15:8];
      6'd20:   header_byte = width[23:16];
      6'd21:   header_byte = width[31:24];
      6'd22:   header_byte = height[7:0];
      6'd23:   header_byte = height[15:8];
      6'd24:   header_byte = height[23:16];
      6'd25:   header_byte = height[31:24];
      6'd26:   header_byte = 8'h01;
      6'd28:   header_byte = 8'h18;
      6'd34:   header_byte = img_size[7:0];
      6'd35:   header_byte = img_size[15:8];
      6'd36:   header_byte = img_size[23:16];
      6'd37:   header_byte = img_size[31:24];
      default: header_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] header_word(input logic [4:0] k, input logic [23:0] n_pix);
    header_word = {header_byte({k, 1'b0}, n_pix), header_byte({k, 1'b1}, n_pix)};
  endfunction
`endif

  // sector FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // sector FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (save_trig) state_nxt_s = START; else state_nxt_s = IDLE;
      START:   state_nxt_s = WAIT;
      WAIT:    if (busy_fall_r && last_sec_s) state_nxt_s = DONE; else state_nxt_s = WAIT;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // sector sequencing outputs; wr_busy fall seen through two delay flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_d1_r   <= 1'b0;
      busy_d2_r   <= 1'b0;
      busy_fall_r <= 1'b0;
      sec_cnt_r   <= 16'd0;
      wr_start_en <= 1'b0;
      wr_sec_addr <= 32'd0;
      save_busy   <= 1'b0;
      save_done   <= 1'b0;
    end else begin
      busy_d1_r   <= wr_busy;
      busy_d2_r   <= busy_d1_r;
      busy_fall_r <= busy_d2_r & ~busy_d1_r;
      wr_start_en <= 1'b0;
      save_done   <= 1'b0;
      case (state_r)
        IDLE: if (save_trig) begin
          save_busy <= 1'b1;
          sec_cnt_r <= 16'd0;
        end
        START: begin
          wr_start_en <= 1'b1;
          wr_sec_addr <= PHOTO_SECTION_ADDR0;
        end
        WAIT: if (busy_fall_r) begin
          wr_sec_addr <= wr_sec_addr + 32'd1;
          if (!last_sec_s) begin
            sec_cnt_r   <= sec_cnt_r + 16'd1;
            wr_start_en <= 1'b1;
          end
        end
        DONE: begin
          save_done <= 1'b1;
          save_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // word stream: header, pixel-pair packing with two-pop fetches, then zero padding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_r     <= REG_PAD;
      word_cnt_r   <= 24'd0;
      pairs_left_r <= 23'd0;
      phase_r      <= 2'd0;
      fetch_step_r <= 2'd0;
      p0_r         <= 24'd0;
      p1_r         <= 24'd0;
      sdr_rd_en    <= 1'b0;
      sd_wr_data   <= 16'd0;
`ifdef BMP_HEADER_EN
      n_pix_r      <= 24'd0;
`endif
    end else begin
      case (fetch_step_r)
        2'd1: fetch_step_r <= 2'd2;
        2'd2: begin
          p0_r         <= sdr_rd_data;
          sdr_rd_en    <= 1'b0;
          fetch_step_r <= 2'd3;
        end
        2'd3: begin
          p1_r         <= sdr_rd_data;
          sd_wr_data   <= {p0_r[7:0], p0_r[15:8]};
          fetch_step_r <= 2'd0;
        end
        default: ;
      endcase

      if (trig_ok_s) begin
        word_cnt_r   <= 24'd0;
        phase_r      <= 2'd0;
        pairs_left_r <= ddr_max_addr[23:1];
`ifdef BMP_HEADER_EN
        n_pix_r      <= {ddr_max_addr[23:1], 1'b0};
        region_r     <= REG_HDR;
        sd_wr_data   <= header_word(5'd0, {ddr_max_addr[23:1], 1'b0});
`else
        sd_wr_data   <= 16'd0;
        if (ddr_max_addr[23:1] != 23'd0) begin
          region_r     <= REG_PIX;
          sdr_rd_en    <= 1'b1;
          fetch_step_r <= 2'd1;
        end else begin
          region_r <= REG_PAD;
        end
`endif
      end else if (sd_wr_req && save_busy) begin
        word_cnt_r <= word_cnt_r + 24'd1;
        if (beyond_end_s) begin
          region_r   <= REG_PAD;
          sd_wr_data <= 16'd0;
        end else begin
          case (region_r)
            REG_HDR: begin
`ifdef BMP_HEADER_EN
              if (word_cnt_r[4:0] == 5'd26) begin
                sd_wr_data <= 16'd0;
                phase_r    <= 2'd0;
                if (pairs_left_r != 23'd0) begin
                  region_r     <= REG_PIX;
                  sdr_rd_en    <= 1'b1;
                  fetch_step_r <= 2'd1;
                end else begin
                  region_r <= REG_PAD;
                end
              end else begin
                sd_wr_data <= header_word(word_cnt_r[4:0] + 5'd1, n_pix_r);
              end
`else
              region_r   <= REG_PAD;
              sd_wr_data <= 16'd0;
`endif
            end
            REG_PIX: begin
              case (phase_r)
                2'd0: begin
                  sd_wr_data <= {p0_r[23:16], p1_r[7:0]};
                  phase_r    <= 2'd1;
                end
                2'd1: begin
                  sd_wr_data <= {p1_r[15:8], p1_r[23:16]};
                  phase_r    <= 2'd2;
                end
                default: begin
                  sd_wr_data   <= 16'd0;
                  phase_r      <= 2'd0;
                  pairs_left_r <= pairs_left_r - 23'd1;
                  if (pairs_left_r != 23'd1) begin
                    sdr_rd_en    <= 1'b1;
                    fetch_step_r <= 2'd1;
                  end else begin
                    region_r <= REG_PAD;
                  end
                end
              endcase
            end
            default: sd_wr_data <= 16'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_write_photo.sv
// Randomized bench for sd_write_photo: models the SD writer and SDRAM, compares the word stream
// against a byte-level BMP reference built from the pixel memory.
module tb_sd_write_photo;

  logic        clk = 1'b0;
  logic        rst_n, save_trig, wr_busy, sd_wr_req;
  logic [23:0] ddr_max_addr;
  logic [23:0] sdr_rd_data = 24'h0;
  logic [15:0] sd_sec_num;
  logic        wr_start_en, sdr_rd_en, save_busy, save_done;
  logic [31:0] wr_sec_addr;
  logic [15:0] sd_wr_data;

  always #5 clk = ~clk;

  sd_write_photo dut (
    .clk(clk), .rst_n(rst_n), .save_trig(save_trig), .ddr_max_addr(ddr_max_addr),
    .sd_sec_num(sd_sec_num), .wr_busy(wr_busy), .sd_wr_req(sd_wr_req), .sdr_rd_data(sdr_rd_data),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .sd_wr_data(sd_wr_data),
    .sdr_rd_en(sdr_rd_en), .save_busy(save_busy), .save_done(save_done)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [23:0] mem [0:63];
  int          rd_ptr = 0;
  int          start_cnt = 0, done_cnt = 0, rden_cnt = 0;
  logic [31:0] addr_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  logic [7:0]  bq [$];

  // SDRAM read port: data one cycle after each pop, pointer rewinds on an accepted trigger
  always @(posedge clk) begin
    if (save_trig && !save_busy) rd_ptr <= 0;
    else if (sdr_rd_en) begin
      sdr_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // event monitor
  always @(posedge clk) begin
    if (wr_start_en) begin
      start_cnt <= start_cnt + 1;
      addr_q.push_back(wr_sec_addr);
    end
    if (save_done) done_cnt <= done_cnt + 1;
    if (sdr_rd_en) rden_cnt <= rden_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vec_cnt);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef BMP_HEADER_EN
  task automatic push_le32(input int v);
    for (int b = 0; b < 4; b++) bq.push_back(8'((v >> (8 * b)) & 255));
  endtask
`endif

  task automatic build_expected(input int npix, input int nsec);
    int n;
    n = npix & ~1;
    bq.delete();
    exp_q.delete();
`ifdef BMP_HEADER_EN
    bq.push_back(8'h42); bq.push_back(8'h4D);
    push_le32(54 + 3 * n); push_le32(0); push_le32(54); push_le32(40);
    push_le32(640); push_le32(480);
    bq.push_back(8'd1); bq.push_back(8'd0); bq.push_back(8'd24); bq.push_back(8'd0);
    push_le32(0); push_le32(3 * n); push_le32(0); push_le32(0); push_le32(0); push_le32(0);
`endif
    for (int p = 0; p < n; p++) begin
      bq.push_back(mem[p][7:0]);
      bq.push_back(mem[p][15:8]);
      bq.push_back(mem[p][23:16]);
    end
    for (int i = 0; i + 1 < bq.size(); i += 2) exp_q.push_back({bq[i], bq[i + 1]});
    while (exp_q.size() < nsec * 256) exp_q.push_back(16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {31'd0, wr_start_en} | wr_sec_addr | {16'd0, sd_wr_data} |
                  {31'd0, sdr_rd_en} | {31'd0, save_busy} | {31'd0, save_done}, 32'd0);
  endtask

  task automatic run_save(input int npix, input int nsec, input bit retrig, input int abort_sec);
    int s0, d0, r0, a0, nreq;
    bit seen;
    s0 = start_cnt; d0 = done_cnt; r0 = rden_cnt; a0 = addr_q.size();
    build_expected(npix, nsec);
    got_q.delete();
    ddr_max_addr = 24'(npix);
    sd_sec_num   = 16'(nsec);
    save_trig = 1'b1; tick(); save_trig = 1'b0;
    check_eq("busy_after_trig", {31'd0, save_busy}, 32'd1);
    for (int s = 0; s < nsec; s++) begin
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        if (start_cnt > s0 + s) seen = 1'b1;
        else tick();
      end
      check_eq($sformatf("start_seen_s%0d", s), {31'd0, seen}, 32'd1);
      if (!seen) return;
      wr_busy = 1'b1;
      nreq = (s == abort_sec) ? 100 : 256;
      for (int w = 0; w < nreq; w++) begin
        repeat ($urandom_range(3, 5)) tick();
        sd_wr_req = 1'b1;
        #3;
        got_q.push_back(sd_wr_data);
        tick();
        sd_wr_req = 1'b0;
        if (retrig && s == 0 && w == 10) begin
          save_trig = 1'b1; tick(); save_trig = 1'b0;
        end
      end
      if (s == abort_sec) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort_outputs");
        tick(); tick();
        rst_n = 1'b1; wr_busy = 1'b0;
        repeat (8) tick();
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_reset_outputs("abort_idle_outputs");
        return;
      end
      repeat (3) tick();
      wr_busy = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done_cnt > d0) seen = 1'b1;
      else tick();
    end
    check_eq("done_seen", {31'd0, seen}, 32'd1);
    repeat (4) tick();
    check_eq("start_count", 32'(start_cnt - s0), 32'(nsec));
    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("rden_count", 32'(rden_cnt - r0), 32'(npix & ~1));
    check_eq("busy_after_done", {31'd0, save_busy}, 32'd0);
    for (int s = 0; s < nsec && a0 + s < addr_q.size(); s++)
      check_eq($sformatf("sec_addr%0d", s), addr_q[a0 + s], 32'd41136 + 32'(s));
    check_eq("word_count", 32'(got_q.size()), 32'(nsec * 256));
    for (int w = 0; w < got_q.size() && w < exp_q.size(); w++)
      check_eq($sformatf("word%0d", w), {16'd0, got_q[w]}, {16'd0, exp_q[w]});
  endtask

  initial begin
    int nz;
    rst_n = 1'b0; save_trig = 1'b0; wr_busy = 1'b0; sd_wr_req = 1'b0;
    ddr_max_addr = 24'd0; sd_sec_num = 16'd1;
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    repeat (3) tick();
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;
    tick();

    mem[0] = 24'hAABBCC;
    mem[1] = 24'h112233;
`ifdef BMP_HEADER_EN
    run_save(4, 1, 1'b0, -1);
    check_eq("hdr_word0", {16'd0, got_q[0]}, 32'h424D);
    check_eq("hdr_word1", {16'd0, got_q[1]}, 32'h4200);
    check_eq("pix_w0", {16'd0, got_q[27]}, 32'hCCBB);
    check_eq("pix_w1", {16'd0, got_q[28]}, 32'hAA33);
    check_eq("pix_w2", {16'd0, got_q[29]}, 32'h2211);
    check_eq("pad_last", {16'd0, got_q[255]}, 32'h0000);
`else
    run_save(2, 1, 1'b0, -1);
    check_eq("pix_w0", {16'd0, got_q[0]}, 32'hCCBB);
    check_eq("pix_w1", {16'd0, got_q[1]}, 32'hAA33);
    check_eq("pix_w2", {16'd0, got_q[2]}, 32'h2211);
    nz = 0;
    foreach (got_q[i]) if (got_q[i] != 16'h0000) nz++;
    check_eq("nonpad_words", 32'(nz), 32'd3);
`endif

    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    run_save(20, 3, 1'b1, -1);

    run_save(10, 3, 1'b0, 1);
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    run_save(12, 1, 1'b0, -1);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
      run_save($urandom_range(0, 60), $urandom_range(1, 2), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
